// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer for the 8-bit alu: streams NBYTES-wide operands through
// the alu one byte per clock, LSB first, chaining carry/borrow between bytes.
module alu_mp_seq #(
  parameter int              NBYTES = 4,
  parameter int              AC_N   = 3,
  parameter logic [AC_N-1:0] AC_AD  = 3'd0,
  parameter logic [AC_N-1:0] AC_SB  = 3'd1,
  parameter logic [AC_N-1:0] AC_AN  = 3'd2,
  parameter logic [AC_N-1:0] AC_OR  = 3'd3,
  localparam int             W      = 8 * NBYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AC_N-1:0] op,
  input  logic            cin,
  input  logic [W-1:0]    opnd_a,
  input  logic [W-1:0]    opnd_b,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            zero,
  output logic            carry,
  output logic [AC_N-1:0] alu_cs,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic            alu_cin,
  input  logic [7:0]      alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout
);

  localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_rem;
  logic [W-1:0]  b_rem;
  logic          zero_acc;
  logic          carry_next;

  // Only add/subtract propagate a carry; every other opcode runs with carry forced to 0.
  function automatic logic is_arith(input logic [AC_N-1:0] code);
    return (code == AC_AD) || (code == AC_SB);
  endfunction

  // Carry that the current byte hands to the next one (and to the final report).
  always_comb begin
    carry_next = 1'b0;
    if (is_arith(alu_cs)) begin
      carry_next = alu_cout;
    end else begin
      carry_next = 1'b0;
    end
  end

  // Sequencer FSM; alu drive is registered so it holds the byte under evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_rem    <= '0;
      b_rem    <= '0;
      zero_acc <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      alu_cs   <= AC_AD;
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
      alu_cin  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            alu_cs   <= op;
            alu_a    <= opnd_a[7:0];
            alu_b    <= opnd_b[7:0];
            alu_cin  <= is_arith(op) ? cin : 1'b0;
            a_rem    <= opnd_a >> 8;
            b_rem    <= opnd_b >> 8;
            idx      <= '0;
            zero_acc <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          result[8*idx +: 8] <= alu_s;
          zero_acc <= zero_acc & alu_zero;
          alu_cin  <= carry_next;
          alu_a    <= a_rem[7:0];
          alu_b    <= b_rem[7:0];
          a_rem    <= a_rem >> 8;
          b_rem    <= b_rem >> 8;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            zero  <= zero_acc & alu_zero;
            carry <= carry_next;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq (NBYTES=2) with a behavioural 8-bit alu attached
// and a word-level reference model for result/zero/carry.
module tb_alu_mp_seq;

  localparam int NB = 2;
  localparam int W  = 8 * NB;
  localparam logic [2:0] AD = 3'd0, SB = 3'd1, AN = 3'd2, OR = 3'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic         cin;
  logic [W-1:0] opnd_a, opnd_b;
  logic         busy, done, zero, carry;
  logic [W-1:0] result;
  logic [2:0]   alu_cs;
  logic [7:0]   alu_a, alu_b, alu_s;
  logic         alu_cin, alu_zero, alu_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mp_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .carry(carry), .alu_cs(alu_cs),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
    .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  // Behavioural 8-bit alu; unknown opcodes give a^b with carry 1 so a leak would show.
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'd0;
    case (alu_cs)
      AD:      alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      SB:      alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
      AN:      alu_t = {1'b0, alu_a & alu_b};
      OR:      alu_t = {1'b0, alu_a | alu_b};
      default: alu_t = {1'b1, alu_a ^ alu_b};
    endcase
    alu_s    = alu_t[7:0];
    alu_cout = alu_t[8];
    alu_zero = (alu_t[7:0] == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: the multi-byte chain must equal plain W-bit arithmetic.
  task automatic ref_model(input logic [2:0] o, input logic c, input logic [W-1:0] a,
                           input logic [W-1:0] b, output logic [W-1:0] r,
                           output logic z, output logic cy);
    logic [W:0] t;
    case (o)
      AD:      t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      SB:      t = {1'b0, a} - {1'b0, b} - (W+1)'(c);
      AN:      t = {1'b0, a & b};
      OR:      t = {1'b0, a | b};
      default: t = {1'b0, a ^ b};
    endcase
    r  = t[W-1:0];
    cy = t[W];
    z  = (t[W-1:0] == '0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    logic [W-1:0] er;
    logic         ez, ec, arith, c1;
    int           k;
    ref_model(o, c, a, b, er, ez, ec);
    arith = (o == AD) || (o == SB);
    if (o == AD) c1 = ((9'(a[7:0]) + 9'(b[7:0]) + 9'(c)) >> 8) != 9'd0;
    else if (o == SB) c1 = (9'(a[7:0]) < (9'(b[7:0]) + 9'(c)));
    else c1 = 1'b0;
    @(negedge clk);
    op = o; cin = c; opnd_a = a; opnd_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opnd_a = W'($urandom); opnd_b = W'($urandom); op = 3'($urandom);
    chk("busy_run", busy, 1);
    k = 1;
    while (!done && k < 10) begin
      if (k <= NB) begin
        chk("alu_a", alu_a, a[8*(k-1) +: 8]);
        chk("alu_b", alu_b, b[8*(k-1) +: 8]);
        chk("alu_cs", alu_cs, o);
        if (k == 1) chk("alu_cin0", alu_cin, arith ? c : 1'b0);
        else if (k == 2) chk("alu_cin1", alu_cin, c1);
      end
      if (poke && k == 1) begin
        start = 1'b1; op = OR; cin = 1'b1; opnd_a = 16'hA5A5; opnd_b = 16'h0F0F;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", k, NB + 1);
    chk("result", result, er);
    chk("zero", zero, ez);
    chk("carry", carry, ec);
    chk("busy_fin", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("no_2nd_done", done, 0);
        chk("idle_busy", busy, 0);
      end
      chk("result_held", result, er);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = AD; cin = 1'b0; opnd_a = '0; opnd_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_alu_cs", alu_cs, AD);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    chk("rst_alu_cin", alu_cin, 0);
    rst_n = 1'b1;

    run_op(AD, 1'b0, 16'h12D4, 16'h342C, 1'b0);
    run_op(AD, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(SB, 1'b0, 16'h0001, 16'h0002, 1'b0);
    run_op(SB, 1'b1, 16'h2A43, 16'h2A42, 1'b0);
    run_op(AN, 1'b1, 16'hD42A, 16'h2C43, 1'b0);
    run_op(OR, 1'b1, 16'hD42A, 16'h2C43, 1'b0);
    run_op(3'd5, 1'b1, 16'h1234, 16'h1234, 1'b0);
    run_op(AD, 1'b1, 16'h00FF, 16'h0000, 1'b1);

    // Abort mid-operation: asynchronous reset must clear everything immediately.
    @(negedge clk);
    op = AD; cin = 1'b1; opnd_a = 16'h80FF; opnd_b = 16'h8001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 0);
    chk("abort_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done, 0);
    run_op(SB, 1'b0, 16'h1000, 16'h0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 5)), 1'($urandom), W'($urandom), W'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
